// File: rtl/multicore_pkg.sv
// Shared types and width constants for the multicore sum-of-squares engine.
// Widths are sized for the largest legal configuration (16 cores, 1024 elements).
package multicore_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    REDUCE  = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam int unsigned MAX_CORES = 16;
  localparam int unsigned MAX_VEC   = 1024;

  localparam int unsigned STEP_W = $clog2(MAX_VEC + 1);
  localparam int unsigned CORE_W = $clog2(MAX_CORES + 1);
  localparam int unsigned IDX_W  = $clog2(MAX_VEC * MAX_CORES) + 1;

  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/multicore_core.sv
// One compute core: generates element(step*CORE_COUNT+id) = index+1 on the fly,
// squares it at DATA_W bits and accumulates while enabled.
module multicore_core
  import multicore_pkg::*;
#(
  parameter int unsigned CORE_COUNT = 6,
  parameter int unsigned VEC_LEN    = 96,
  parameter int unsigned DATA_W     = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              enable_i,
  input  logic [STEP_W-1:0] index_i,
  input  logic [CORE_W-1:0] core_id_i,
  output logic [DATA_W-1:0] partial_o
);

  logic [IDX_W-1:0]  elem_idx_c;
  logic [DATA_W-1:0] elem_c;
  logic [DATA_W-1:0] square_c;
  logic [DATA_W-1:0] acc_d;
  logic [DATA_W-1:0] acc_q;

  // Out-of-range indices (tail step, surplus cores) contribute zero.
  always_comb begin
    elem_idx_c = IDX_W'(index_i) * IDX_W'(CORE_COUNT) + IDX_W'(core_id_i);
    elem_c     = DATA_W'(elem_idx_c) + DATA_W'(1);
    square_c   = elem_c * elem_c;
    acc_d      = acc_q;
    if (enable_i && (elem_idx_c < IDX_W'(VEC_LEN))) begin
      acc_d = acc_q + square_c;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || clear_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign partial_o = acc_q;

endmodule

// File: rtl/multicore_top.sv
// Controller for CORE_COUNT parallel sum-of-squares cores: launch, serial reduce, done.
// Optional cycleCount output is built when PERF_COUNTER_EN is defined.
module multicore_top
  import multicore_pkg::*;
#(
  parameter int unsigned CORE_COUNT = 6,
  parameter int unsigned VEC_LEN    = 96,
  parameter int unsigned DATA_W     = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              processorReady,
  output logic              processDone,
`ifdef PERF_COUNTER_EN
  output logic [15:0]       cycleCount,
`endif
  output logic [DATA_W-1:0] result
);

  localparam int unsigned STEPS = ceil_div(VEC_LEN, CORE_COUNT);

  state_e              state_q;
  logic [STEP_W-1:0]   step_q;
  logic [CORE_W-1:0]   sel_q;
  logic [DATA_W-1:0]   result_q;
  logic                ready_q;
  logic                done_q;
  logic                launch_c;
  logic                compute_c;
  logic [DATA_W-1:0]   partial [CORE_COUNT];

  assign launch_c  = start && ((state_q == IDLE) || (state_q == DONE));
  assign compute_c = (state_q == COMPUTE);

  for (genvar k = 0; k < CORE_COUNT; k++) begin : g_core
    multicore_core #(
      .CORE_COUNT (CORE_COUNT),
      .VEC_LEN    (VEC_LEN),
      .DATA_W     (DATA_W)
    ) u_core (
      .clock     (clock),
      .reset     (reset),
      .clear_i   (launch_c),
      .enable_i  (compute_c),
      .index_i   (step_q),
      .core_id_i (CORE_W'(k)),
      .partial_o (partial[k])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      step_q   <= '0;
      sel_q    <= '0;
      result_q <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q  <= COMPUTE;
            step_q   <= '0;
            sel_q    <= '0;
            result_q <= '0;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
          end
        end
        COMPUTE: begin
          if (step_q == STEP_W'(STEPS - 1)) begin
            state_q <= REDUCE;
            sel_q   <= '0;
          end else begin
            step_q <= step_q + STEP_W'(1);
          end
        end
        REDUCE: begin
          // One partial per cycle, core 0 first.
          result_q <= result_q + partial[sel_q];
          if (sel_q == CORE_W'(CORE_COUNT - 1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            sel_q <= sel_q + CORE_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef PERF_COUNTER_EN
  logic [15:0] cycle_q;

  always_ff @(posedge clock) begin
    if (reset || launch_c) begin
      cycle_q <= '0;
    end else if ((state_q == COMPUTE) || (state_q == REDUCE)) begin
      cycle_q <= cycle_q + 16'd1;
    end
  end

  assign cycleCount = cycle_q;
`endif

  assign processorReady = ready_q;
  assign processDone    = done_q;
  assign result         = result_q;

endmodule

// File: tb/tb_multicore_top.sv
// Directed bench: three configurations (6/96, 1/4, 8/5) with hand-computed results and latencies.
module tb_multicore_top;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start0 = 1'b0;
  logic        start1 = 1'b0;
  logic        start2 = 1'b0;
  logic        ready0, ready1, ready2;
  logic        done0, done1, done2;
  logic [31:0] res0, res1, res2;
`ifdef PERF_COUNTER_EN
  logic [15:0] cyc0, cyc1, cyc2;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  multicore_top #(.CORE_COUNT(6), .VEC_LEN(96), .DATA_W(32)) dut0 (
    .clock(clock), .reset(reset), .start(start0),
    .processorReady(ready0), .processDone(done0),
`ifdef PERF_COUNTER_EN
    .cycleCount(cyc0),
`endif
    .result(res0)
  );

  multicore_top #(.CORE_COUNT(1), .VEC_LEN(4), .DATA_W(32)) dut1 (
    .clock(clock), .reset(reset), .start(start1),
    .processorReady(ready1), .processDone(done1),
`ifdef PERF_COUNTER_EN
    .cycleCount(cyc1),
`endif
    .result(res1)
  );

  multicore_top #(.CORE_COUNT(8), .VEC_LEN(5), .DATA_W(32)) dut2 (
    .clock(clock), .reset(reset), .start(start2),
    .processorReady(ready2), .processDone(done2),
`ifdef PERF_COUNTER_EN
    .cycleCount(cyc2),
`endif
    .result(res2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic done_of(input int w);
    case (w)
      0:       return done0;
      1:       return done1;
      default: return done2;
    endcase
  endfunction

  function automatic logic ready_of(input int w);
    case (w)
      0:       return ready0;
      1:       return ready1;
      default: return ready2;
    endcase
  endfunction

  task automatic set_start(input int w, input logic v);
    case (w)
      0:       start0 = v;
      1:       start1 = v;
      default: start2 = v;
    endcase
  endtask

  // lat = number of rising edges after the start-sampling edge until processDone is seen.
  task automatic run(input int w, input int hold, input string tag, output int lat);
    set_start(w, 1'b1);
    tick();
    check({tag, "_busy_ready"}, 32'(ready_of(w)), 32'd0);
    lat = 0;
    for (int i = 1; i < hold; i++) begin
      tick();
      lat++;
    end
    set_start(w, 1'b0);
    while (!done_of(w) && lat < 200) begin
      tick();
      lat++;
    end
    if (!done_of(w)) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
    end
  endtask

  int lat;

  initial begin
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("rst_ready0", 32'(ready0), 32'd1);
    check("rst_done0",  32'(done0),  32'd0);
    check("rst_result0", res0, 32'd0);
    check("rst_ready2", 32'(ready2), 32'd1);
`ifdef PERF_COUNTER_EN
    check("rst_cycles0", 32'(cyc0), 32'd0);
`endif

    // Defaults: 96*97*193/6 = 299536, done at edge 16+6.
    run(0, 1, "def", lat);
    check("def_latency", 32'(lat), 32'd22);
    check("def_result", res0, 32'd299536);
    check("def_ready_done", 32'(ready0), 32'd0);
`ifdef PERF_COUNTER_EN
    check("def_cycles", 32'(cyc0), 32'd22);
`endif

    // Single core, 4 elements: 1+4+9+16.
    run(1, 1, "c1v4", lat);
    check("c1v4_latency", 32'(lat), 32'd5);
    check("c1v4_result", res1, 32'd30);

    // Surplus cores: 1+4+9+16+25, one compute step plus 8 reduce cycles.
    run(2, 1, "c8v5", lat);
    check("c8v5_latency", 32'(lat), 32'd9);
    check("c8v5_result", res2, 32'd55);

    // Abort mid-run: reset sampled at edge 10 after the start edge.
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_ready", 32'(ready0), 32'd1);
    check("abort_done", 32'(done0), 32'd0);
    check("abort_result", res0, 32'd0);
    run(0, 1, "rerun", lat);
    check("rerun_latency", 32'(lat), 32'd22);
    check("rerun_result", res0, 32'd299536);

    // Hold start for 5 cycles: no restart, no stretch.
    run(0, 5, "hold", lat);
    check("hold_latency", 32'(lat), 32'd22);
    check("hold_result", res0, 32'd299536);
    tick();
    tick();
    check("hold_result_held", res0, 32'd299536);
    check("hold_done_held", 32'(done0), 32'd1);

    // Restart from DONE: processDone drops on the start edge.
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    check("restart_done_drop", 32'(done0), 32'd0);
    check("restart_result_clr", res0, 32'd0);
    lat = 0;
    while (!done0 && lat < 200) begin
      tick();
      lat++;
    end
    check("restart_latency", 32'(lat), 32'd22);
    check("restart_result", res0, 32'd299536);
`ifdef PERF_COUNTER_EN
    check("restart_cycles", 32'(cyc0), 32'd22);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
